imem_loader: RTL

Boot-time writer for the instruction memory that the RV32I core reads at fetch. It consumes a byte stream from a UART receiver over a valid/ready handshake. It assembles little-endian 32-bit words and writes them sequentially into the instruction memory write port. While loading, it holds the core in reset, and releases the core only after a verified image has been written.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_word_packer.sv | 62 ++++++
 rtl/imem_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_LO  = 3'd1,
    LEN_HI  = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_SUM     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; the word and its
// strobe are registered and appear the cycle after the fourth byte.
module word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;

  assign word_last  = (cnt_q == 2'd3);
  assign word_valid = word_valid_q;
  assign word       = word_q;

  // Next-state for byte counter, shift register and word output.
  always_comb begin
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clear) begin
      cnt_d = 2'd0;
      sr_d  = 32'd0;
    end else if (in_valid) begin
      // New bytes enter at the top so the first byte ends up least significant.
      sr_d  = {in_byte, sr_q[31:8]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        word_valid_d = 1'b1;
        word_d       = {in_byte, sr_q[31:8]};
      end else begin
        word_valid_d = 1'b0;
      end
    end else begin
      word_valid_d = 1'b0;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 2'd0;
      sr_q         <= 32'd0;
      word_valid_q <= 1'b0;
      word_q       <= 32'd0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed image over a byte
// stream, writes it to instruction memory and holds the core until it verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [15:0]     MAX_LEN  = 16'(MAX_WORDS);

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            rx_ready_q, rx_ready_d;
  logic            busy_q, busy_d;
  logic            core_hold_q, core_hold_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [15:0]     word_count_q, word_count_d;
  logic [31:0]     imem_addr_q, imem_addr_d;

  logic            accept_s;
  logic            timeout_s;
  logic [TO_W-1:0] to_inc_s;
  logic [15:0]     len_s;
  logic            pk_valid_s;
  logic            pk_clear_s;
  logic            pk_last_s;
  logic            pk_word_valid_s;
  logic [31:0]     pk_word_s;

  assign accept_s   = rx_valid && rx_ready_q;
  assign to_inc_s   = to_q + TO_W'(1);
  assign timeout_s  = busy_q && !accept_s && (to_inc_s == TO_LIMIT);
  assign len_s      = {rx_data, len_q[7:0]};
  assign pk_valid_s = accept_s && (state_q == PAYLOAD);

  word_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (pk_clear_s),
    .in_valid   (pk_valid_s),
    .in_byte    (rx_data),
    .word_last  (pk_last_s),
    .word_valid (pk_word_valid_s),
    .word       (pk_word_s)
  );

  // FSM next-state, checksum, timeout and write address.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    err_code_d   = err_code_q;
    word_count_d = word_count_q;
    imem_addr_d  = imem_addr_q;
    pk_clear_s   = 1'b0;
    if (busy_q) begin
      to_d = accept_s ? '0 : to_inc_s;
    end else begin
      to_d = to_q;
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d      = LEN_LO;
          len_d        = 16'd0;
          sum_d        = 8'd0;
          to_d         = '0;
          err_code_d   = ERR_NONE;
          word_count_d = 16'd0;
          pk_clear_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      LEN_LO: begin
        if (accept_s) begin
          len_d   = {8'd0, rx_data};
          state_d = LEN_HI;
        end else begin
          state_d = LEN_LO;
        end
      end
      LEN_HI: begin
        if (accept_s) begin
          len_d = len_s;
          if ((len_s == 16'd0) || (len_s > MAX_LEN)) begin
            state_d    = ERROR;
            err_code_d = ERR_LEN;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = LEN_HI;
        end
      end
      PAYLOAD: begin
        if (accept_s) begin
          sum_d = sum_q + rx_data;
          if (pk_last_s) begin
            word_count_d = word_count_q + 16'd1;
            imem_addr_d  = word_addr(BASE_ADDR, word_count_q);
            if ((word_count_q + 16'd1) == len_q) begin
              state_d = CHECK;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      CHECK: begin
        if (accept_s) begin
          if (rx_data == sum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERROR;
            err_code_d = ERR_SUM;
          end
        end else begin
          state_d = CHECK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any partially packed word is dropped on timeout.
    if (timeout_s) begin
      state_d    = ERROR;
      err_code_d = ERR_TIMEOUT;
      to_d       = '0;
      pk_clear_s = 1'b1;
    end else begin
      pk_clear_s = pk_clear_s;
    end

    busy_d      = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                  (state_d == PAYLOAD) || (state_d == CHECK);
    rx_ready_d  = busy_d;
    core_hold_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= 16'd0;
      sum_q        <= 8'd0;
      to_q         <= '0;
      rx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      core_hold_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      word_count_q <= 16'd0;
      imem_addr_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      to_q         <= to_d;
      rx_ready_q   <= rx_ready_d;
      busy_q       <= busy_d;
      core_hold_q  <= core_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      word_count_q <= word_count_d;
      imem_addr_q  <= imem_addr_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign busy       = busy_q;
  assign core_hold  = core_hold_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign word_count = word_count_q;
  assign imem_addr  = imem_addr_q;
  assign imem_we    = pk_word_valid_s;
  assign imem_wdata = pk_word_s;

endmodule
